saph_fpu_arbiter: RTL
=====================

Name: saph_fpu_arbiter

Overview:
- Shares one FPU issue port among NREQ requesters (e.g. several saph_float_incrementer-style sequencers) so that the FPU is time-multiplexed instead of duplicated.
- Round-robin grant on a valid/ready issue handshake.
- Requester index of each in-flight op is held in an in-order tag FIFO, so each FPU result is routed back to the requester that issued it.
- Sits between the requester blocks and the FPU's issue/result port, one instance per shared FPU port.

Parameters:
- NREQ, 2, number of requesters (>=2).
- LANES, 2, float lanes per operation.
- OPW, 4, FPU opcode width.
- DEPTH, 4, max outstanding ops (tag FIFO depth, power of two, >= FPU latency for full throughput).

Ports:
- clk  in  1  GPU clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  [NREQ]  requester i has an op pending.
- req_ready  out  [NREQ]  requester i's op accepted this cycle.
- req_op  in  [NREQ][OPW]  opcode per requester.
- req_a  in  [NREQ][LANES] float  operand A per requester.
- req_b  in  [NREQ][LANES] float  operand B per requester.
- resp_valid  out  [NREQ]  one-hot result strobe.
- resp_res  out  [LANES] float  result, shared by all requesters.
- fpu_valid  out  1  issue to FPU.
- fpu_ready  in  1  FPU accepts issue.
- fpu_op  out  OPW  opcode to FPU.
- fpu_a  out  [LANES] float  operand A to FPU.
- fpu_b  out  [LANES] float  operand B to FPU.
- fpu_res_valid  in  1  FPU result strobe (in issue order).
- fpu_res  in  [LANES] float  FPU result.

Behaviour:
- Reset (async, rst=1): ptr=NREQ-1, tag FIFO empty (rd=wr=count=0), resp_valid=0, resp_res=0. Requester 0 therefore has first priority after reset.
- Selection (comb):
  - sel = first i with req_valid[i], scanning ptr+1, ptr+2, ... modulo NREQ.
  - space = (count<DEPTH) | pop, where pop = fpu_res_valid.
  - fpu_valid = (|req_valid) & space; fpu_op/a/b = mux of sel.
  - fpu_valid never depends on fpu_ready.
- Issue:
  - fire = fpu_valid & fpu_ready.
  - req_ready[sel] = fire; all other req_ready bits are 0.
  - On fire: push sel to the FIFO and set ptr<=sel.
  - ptr is unchanged when there is no fire, so a stalled grant holds.
- Requesters hold op/a/b stable while req_valid is high and req_ready is low; the arbiter does not register operands (zero added issue latency).
- Response:
  - On fpu_res_valid: pop the FIFO head h.
  - Next cycle: resp_valid = one-hot(h) and resp_res = fpu_res (1-cycle registered latency).
  - resp_valid is a single-cycle pulse.
- Simultaneous push and pop: count is unchanged. Issue is allowed when count==DEPTH if a pop occurs in the same cycle.
- Full with no pop: fpu_valid=0 and all req_ready=0.
- fpu_res_valid while the FIFO is empty: the result is dropped, resp_valid stays 0, FIFO pointers do not move.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Fairness: with all requesters continuously valid and the FPU always ready, grants cycle 0,1,..,NREQ-1,0,... with exactly one grant per cycle.

Optional Feature:
- Macro SAPH_FPU_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt [NREQ][16], one saturating counter per requester incremented on each of its grants.
  - Adds output spurious, a sticky bit set on fpu_res_valid with an empty FIFO and cleared only by rst.
  - Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- saph_defines.svh / shared package: the float typedef (already present), `fconst, and the opcode typedef saph_fpu_op_t of width OPW.
- Sub-module saph_tag_fifo (parameters W, DEPTH):
  - in-order FIFO with push/pop/full/empty/count;
  - async reset;
  - pop and push in the same cycle are legal when full.
- The arbiter is otherwise a single module.

Test Plan:
- Single requester: req 0 issues ADD `fconst(1.0),`fconst(2.0) with a model FPU of latency 3. Required: req_ready[0] in cycle t, resp_valid=2'b01 at t+4, resp_res=`fconst(3.0).
- Both requesters continuously valid, FPU always ready. Required: grants 0,1,0,1 on consecutive cycles; responses return in the same order to the matching requester.
- fpu_ready low for 5 cycles with both requesters valid. Required: sel is held, no req_ready pulses, ptr unchanged, and req 0 is granted first when fpu_ready rises (after reset).
- DEPTH=4 with FPU latency 8. Required: 4 issues, then fpu_valid=0 until the first result; in that result cycle a 5th issue fires while count stays 4.
- Spurious fpu_res_valid with an empty FIFO. Required: no resp_valid; spurious=1 when SAPH_FPU_ARB_STATS_EN is defined.
- rst asserted mid-stream with 3 ops in flight. Required: outputs clear immediately (asynchronously), the FIFO is empty, and post-reset results are dropped until new issues.

Source files
------------

// File: rtl/saph_fpu_arbiter_pkg.sv
// Shared types for the FPU issue-port arbiter.
//   saph_float_t   : single-precision float bit pattern
//   saph_fpu_op_t  : FPU opcode
//   FC_*           : common float constants
//   rr_idx         : round-robin candidate index helper
package saph_fpu_arbiter_pkg;

    localparam int SAPH_FW  = 32;
    localparam int SAPH_OPW = 4;

    typedef logic [SAPH_FW-1:0] saph_float_t;

    typedef enum logic [SAPH_OPW-1:0] {
        FPU_ADD = 4'h0,
        FPU_SUB = 4'h1,
        FPU_MUL = 4'h2
    } saph_fpu_op_t;

    localparam saph_float_t FC_0_0 = 32'h0000_0000;
    localparam saph_float_t FC_1_0 = 32'h3F80_0000;
    localparam saph_float_t FC_2_0 = 32'h4000_0000;
    localparam saph_float_t FC_3_0 = 32'h4040_0000;

    // k-th candidate after base in a ring of n requesters.
    function automatic int rr_idx(int base, int k, int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/saph_fpu_arbiter_if.sv
// Requester/FPU bundle for saph_fpu_arbiter.
//   slave  : arbiter side (takes requests and FPU results, drives grants,
//            responses and the FPU issue port)
//   master : environment side (requesters + FPU)
// Signals: req_valid/req_ready/req_op/req_a/req_b, resp_valid/resp_res,
//          fpu_valid/fpu_ready/fpu_op/fpu_a/fpu_b, fpu_res_valid/fpu_res.
interface saph_fpu_arbiter_if
    import saph_fpu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LANES = 2,
    parameter int OPW   = 4
);
    logic        [NREQ-1:0]             req_valid;
    logic        [NREQ-1:0]             req_ready;
    logic        [NREQ-1:0][OPW-1:0]    req_op;
    saph_float_t [NREQ-1:0][LANES-1:0]  req_a;
    saph_float_t [NREQ-1:0][LANES-1:0]  req_b;
    logic        [NREQ-1:0]             resp_valid;
    saph_float_t [LANES-1:0]            resp_res;
    logic                               fpu_valid;
    logic                               fpu_ready;
    logic        [OPW-1:0]              fpu_op;
    saph_float_t [LANES-1:0]            fpu_a;
    saph_float_t [LANES-1:0]            fpu_b;
    logic                               fpu_res_valid;
    saph_float_t [LANES-1:0]            fpu_res;

    modport slave (
        input  req_valid, req_op, req_a, req_b, fpu_ready, fpu_res_valid, fpu_res,
        output req_ready, resp_valid, resp_res, fpu_valid, fpu_op, fpu_a, fpu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, fpu_ready, fpu_res_valid, fpu_res,
        input  req_ready, resp_valid, resp_res, fpu_valid, fpu_op, fpu_a, fpu_b
    );
endinterface

// File: rtl/saph_tag_fifo.sv
// In-order tag FIFO holding the requester index of each in-flight FPU op.
// Ports: clk, rst (async, active high), push/din, pop/dout (head),
//        full, empty, count.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module saph_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop)  rd <= rd + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter sharing one FPU issue port among NREQ requesters.
// Issue is combinational (operands are muxed straight through); each
// accepted op's requester index goes into an in-order tag FIFO so the
// FPU result is steered back as a one-cycle registered response.
// Ports: clk, rst (async, active high), bus (saph_fpu_arbiter_if.slave).
// Optional SAPH_FPU_ARB_STATS_EN adds:
//   grant_cnt : per-requester saturating 16-bit grant counters
//   spurious  : sticky flag, FPU result seen with no op in flight
module saph_fpu_arbiter
    import saph_fpu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LANES = 2,
    parameter int OPW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    saph_fpu_arbiter_if.slave      bus
`ifdef SAPH_FPU_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]  grant_cnt,
    output logic                   spurious
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IW-1:0]            ptr, sel, cand, head;
    logic                     found;
    logic                     space, fpu_valid_i, fire, pop_ok;
    logic                     fifo_full, fifo_empty;
    logic [CW-1:0]            fifo_count_unused;
    logic [NREQ-1:0]          resp_valid_q;
    saph_float_t [LANES-1:0]  resp_res_q;

    // First valid requester after the last grant; ptr itself is last in line.
    always_comb begin
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'(rr_idx(int'(ptr), k, NREQ));
            if (!found && bus.req_valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // A result leaving this cycle frees a slot, so a full FIFO can still issue.
    assign space       = ~fifo_full | bus.fpu_res_valid;
    assign fpu_valid_i = (|bus.req_valid) & space;
    assign fire        = fpu_valid_i & bus.fpu_ready;
    assign pop_ok      = bus.fpu_res_valid & ~fifo_empty;

    assign bus.fpu_valid  = fpu_valid_i;
    assign bus.fpu_op     = bus.req_op[sel];
    assign bus.fpu_a      = bus.req_a[sel];
    assign bus.fpu_b      = bus.req_b[sel];
    assign bus.req_ready  = fire ? (NREQ'(1) << sel) : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_res   = resp_res_q;

    saph_tag_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .din   (sel),
        .pop   (pop_ok),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // ptr only moves on an accepted issue, so a stalled grant keeps its winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= IW'(NREQ - 1);
            resp_valid_q <= '0;
            resp_res_q   <= '0;
        end else begin
            if (fire) ptr <= sel;
            resp_valid_q <= pop_ok ? (NREQ'(1) << head) : '0;
            if (pop_ok) resp_res_q <= bus.fpu_res;
        end
    end

`ifdef SAPH_FPU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            spurious  <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (fire && sel == IW'(i) && grant_cnt[i] != 16'hFFFF)
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (bus.fpu_res_valid && fifo_empty) spurious <= 1'b1;
        end
    end
`endif
endmodule
